mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter N_CH, default 3, number of requesting channels (2..8); index 0 = dcache write-back, 1 = dcache read, 2 = icache read.
REQ-002 Parameter ADDR_WIDTH, default 64, byte address width.
REQ-003 Parameter BLOCK_WIDTH, default 512, cache block width in bits; power of two, >= 64.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 i_arst  in  1  reset, synchronous, active-low.
REQ-006 i_req  in  N_CH  per-channel request; held high until matching o_done pulse.
REQ-007 i_we  in  N_CH  per-channel write flag (1 = block write, 0 = block read).
REQ-008 i_addr  in  N_CH*ADDR_WIDTH  per-channel byte address, channel k in slice k.
REQ-009 i_wdata  in  N_CH*BLOCK_WIDTH  per-channel write block, channel k in slice k.
REQ-010 i_axi_done  in  1  bus transaction complete, single-cycle pulse.
REQ-011 o_axi_addr  out  ADDR_WIDTH  block-aligned address of granted transaction.
REQ-012 o_data_block  out  BLOCK_WIDTH  latched write block of granted transaction.
REQ-013 o_axi_write_start  out  1  one-cycle write start pulse.
REQ-014 o_axi_read_start  out  1  one-cycle read start pulse.
REQ-015 o_grant  out  N_CH  one-hot owner of current transaction, zero when idle.
REQ-016 o_done  out  N_CH  one-cycle completion pulse to owner.
REQ-017 o_busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE with any i_req bit set SHALL select one winner, latch its we/addr/wdata, set o_grant, go to ISSUE next edge.
REQ-020 ISSUE SHALL last exactly one cycle, asserting o_axi_write_start if latched we=1 else o_axi_read_start, never both.
REQ-021 ISSUE with i_axi_done=0 SHALL go to WAIT; i_axi_done=1 in ISSUE or WAIT SHALL go to RESP.
REQ-022 RESP SHALL last one cycle, assert o_done[owner] only, clear o_grant at exit, return to IDLE.
REQ-023 o_axi_addr SHALL equal latched address with low $clog2(BLOCK_WIDTH/8) bits forced to zero (6 bits at 512).
REQ-024 o_axi_addr, o_data_block, o_grant SHALL stay stable from ISSUE through RESP regardless of input changes.
REQ-025 Latency: request seen in IDLE at edge t -> start pulse cycle t+1; i_axi_done at cycle n -> o_done at n+1; next grant earliest in ISSUE at n+3.
REQ-026 i_axi_done in IDLE or RESP SHALL be ignored.
REQ-027 Owner deasserting i_req mid-transaction SHALL NOT abort it; o_done still pulses.
REQ-028 Non-owner i_req SHALL wait without loss; no channel starves under REQ-031 mode.
REQ-029 i_we/i_addr/i_wdata of non-winning channels SHALL be don't-care.

Reset
REQ-030 i_arst=0 at an edge SHALL force IDLE, o_grant=0, o_done=0, both start pulses 0, o_busy=0, o_axi_addr=0, o_data_block=0, round-robin pointer to N_CH-1, from any state including mid-transaction.

Configuration
REQ-031 Macro MEM_ARB_ROUND_ROBIN_EN defined: winner SHALL be first requesting channel searching upward (wrapping) from last-granted index+1; pointer updated on each grant.
REQ-032 MEM_ARB_ROUND_ROBIN_EN undefined: winner SHALL be lowest requesting index (fixed priority, write-back first); no pointer logic.

Verification
REQ-033 Single read: i_req=3'b100, addr 0x1234_5678, done 4 cycles after start -> o_axi_read_start one cycle, o_axi_addr=0x1234_5640, o_done=3'b100 cycle after done.
REQ-034 Write: i_req=3'b001, we=1, wdata pattern A5.. -> o_axi_write_start one cycle, o_data_block=A5.. held until RESP.
REQ-035 Simultaneous i_req=3'b111, fixed priority -> grants in order 0,1,2; round-robin from reset -> 0,1,2, then with ch0,ch2 re-requesting after ch0 grant -> next is 2.
REQ-036 i_axi_done during ISSUE cycle -> direct to RESP, o_done next cycle, no WAIT cycle.
REQ-037 i_arst=0 during WAIT, then late i_axi_done -> outputs at reset values, no o_done, no spurious start.
REQ-038 Stray i_axi_done in IDLE, and owner drops i_req in WAIT -> no state change in IDLE; transaction completes with o_done.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - cache-to-bus block request arbiter (IDLE/ISSUE/WAIT/RESP)
// Optional round-robin selection via MEM_ARB_ROUND_ROBIN_EN; fixed priority otherwise.
module mem_req_arbiter #(
  parameter int N_CH        = 3,
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512
) (
  input  logic                        i_clk,
  input  logic                        i_arst,
  input  logic [N_CH-1:0]             i_req,
  input  logic [N_CH-1:0]             i_we,
  input  logic [N_CH*ADDR_WIDTH-1:0]  i_addr,
  input  logic [N_CH*BLOCK_WIDTH-1:0] i_wdata,
  input  logic                        i_axi_done,
  output logic [ADDR_WIDTH-1:0]       o_axi_addr,
  output logic [BLOCK_WIDTH-1:0]      o_data_block,
  output logic                        o_axi_write_start,
  output logic                        o_axi_read_start,
  output logic [N_CH-1:0]             o_grant,
  output logic [N_CH-1:0]             o_done,
  output logic                        o_busy
);

  localparam int IDXW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int OFF  = $clog2(BLOCK_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state, state_next;
  logic                   win_valid;
  logic [IDXW-1:0]        win_idx;
  logic                   win_we;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [BLOCK_WIDTH-1:0] win_data;
  logic                   we_q;

  assign win_valid = |i_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0]   rr_ptr;
  logic [2*N_CH-1:0] req_dbl;
  logic [2*N_CH-1:0] req_shift;
  logic [N_CH-1:0]   req_rot;

  // Rotate requests so bit 0 is the channel just after the last grant;
  // a shift amount that wraps in IDXW bits is still a whole-turn rotation.
  always_comb begin
    req_dbl   = {i_req, i_req};
    req_shift = req_dbl >> (rr_ptr + 1'b1);
    req_rot   = req_shift[N_CH-1:0];
    win_idx   = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (req_rot[j]) win_idx = IDXW'((int'(rr_ptr) + 1 + j) % N_CH);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_arst) begin
      rr_ptr <= IDXW'(N_CH - 1);
    end else if (state == IDLE && win_valid) begin
      rr_ptr <= win_idx;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (i_req[j]) win_idx = IDXW'(j);
    end
  end
`endif

  always_comb begin
    win_we   = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (win_idx == IDXW'(k)) begin
        win_we   = i_we[k];
        win_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        win_data = i_wdata[k*BLOCK_WIDTH +: BLOCK_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_arst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next        = state;
    o_axi_write_start = 1'b0;
    o_axi_read_start  = 1'b0;
    o_done            = '0;
    o_busy            = (state != IDLE);
    case (state)
      IDLE:  if (win_valid) state_next = ISSUE;
      ISSUE: begin
        o_axi_write_start = we_q;
        o_axi_read_start  = ~we_q;
        state_next        = i_axi_done ? RESP : WAIT;
      end
      WAIT:  if (i_axi_done) state_next = RESP;
      RESP: begin
        o_done     = o_grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction attributes are captured once at grant and held until the
  // next grant, so input churn during ISSUE..RESP cannot leak onto the bus.
  always_ff @(posedge i_clk) begin
    if (!i_arst) begin
      we_q         <= 1'b0;
      o_axi_addr   <= '0;
      o_data_block <= '0;
      o_grant      <= '0;
    end else if (state == IDLE && win_valid) begin
      we_q         <= win_we;
      o_axi_addr   <= win_addr & ALIGN_MASK;
      o_data_block <= win_data;
      o_grant      <= N_CH'(1) << win_idx;
    end else if (state == RESP) begin
      o_grant      <= '0;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter
module tb_mem_req_arbiter;
  localparam int N_CH = 3;
  localparam int AW   = 64;
  localparam int BW   = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 arst;
  logic [N_CH-1:0]      req, we;
  logic [N_CH*AW-1:0]   addr;
  logic [N_CH*BW-1:0]   wdata;
  logic                 axi_done;
  logic [AW-1:0]        o_axi_addr;
  logic [BW-1:0]        o_data_block;
  logic                 o_axi_write_start, o_axi_read_start;
  logic [N_CH-1:0]      o_grant, o_done;
  logic                 o_busy;

  mem_req_arbiter #(.N_CH(N_CH), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .i_clk(clk), .i_arst(arst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_axi_done(axi_done), .o_axi_addr(o_axi_addr),
    .o_data_block(o_data_block), .o_axi_write_start(o_axi_write_start),
    .o_axi_read_start(o_axi_read_start), .o_grant(o_grant), .o_done(o_done),
    .o_busy(o_busy)
  );

  typedef struct {
    int          ch;
    logic        we;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } txn_t;

  txn_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
    we[ch]             = w;
    addr[ch*AW +: AW]  = a;
    wdata[ch*BW +: BW] = d;
  endtask

  // Expected bus address is the byte address with the 6 offset bits of a 64-byte block cleared.
  task automatic push(input int ch);
    txn_t t;
    t.ch   = ch;
    t.we   = we[ch];
    t.addr = addr[ch*AW +: AW] & ~64'h3F;
    t.data = wdata[ch*BW +: BW];
    sb.push_back(t);
  endtask

  task automatic serve(input int dly, input bit drop_early);
    int              cnt;
    txn_t            e;
    logic [N_CH-1:0] oh;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(o_axi_write_start || o_axi_read_start) && cnt < 30);
    chk("start_latency", cnt, 1);
    if (!(o_axi_write_start || o_axi_read_start)) return;
    e  = sb.pop_front();
    oh = N_CH'(1) << e.ch;
    chk("write_start", o_axi_write_start, e.we);
    chk("read_start", o_axi_read_start, !e.we);
    chk("grant", o_grant, oh);
    chk("axi_addr", o_axi_addr, e.addr);
    chk("data_block", o_data_block, e.data);
    chk("busy_issue", o_busy, 1'b1);
    if (dly == 0) axi_done = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("wait_no_start", {o_axi_write_start, o_axi_read_start}, 2'b00);
      chk("wait_grant", o_grant, oh);
      chk("wait_addr", o_axi_addr, e.addr);
      chk("wait_data", o_data_block, e.data);
      chk("wait_done", o_done, 0);
      if (drop_early && i == 0) req[e.ch] = 1'b0;
      if (i == dly - 1) axi_done = 1'b1;
    end
    @(negedge clk);
    axi_done = 1'b0;
    chk("done_pulse", o_done, oh);
    chk("resp_grant", o_grant, oh);
    chk("resp_data", o_data_block, e.data);
    req[e.ch] = 1'b0;
    @(negedge clk);
    chk("done_clear", o_done, 0);
    chk("grant_clear", o_grant, 0);
    chk("busy_idle", o_busy, 1'b0);
  endtask

  initial begin
    int   cnt;
    txn_t e;
    arst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; axi_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_grant", o_grant, 0);
    chk("rst_done", o_done, 0);
    chk("rst_starts", {o_axi_write_start, o_axi_read_start}, 2'b00);
    chk("rst_addr", o_axi_addr, 0);
    chk("rst_data", o_data_block, 0);
    arst = 1'b1;
    @(negedge clk);

    // single read on icache channel, done 4 cycles after start
    set_ch(2, 1'b0, 64'h1234_5678, {16{32'hDEAD_BEEF}});
    req = 3'b100; push(2);
    serve(4, 1'b0);
    chk("read_addr_literal", o_axi_addr, 64'h1234_5640);

    // write-back block write with A5 pattern
    set_ch(0, 1'b1, 64'h0000_0000_8000_00C7, {64{8'hA5}});
    req = 3'b001; push(0);
    serve(3, 1'b0);

    // done during ISSUE goes straight to RESP
    set_ch(1, 1'b0, 64'hFFFF_0000_0000_1FFF, {8{64'h0123_4567_89AB_CDEF}});
    req = 3'b010; push(1);
    serve(0, 1'b0);

    // stray done while idle
    axi_done = 1'b1;
    @(negedge clk);
    axi_done = 1'b0;
    chk("stray_busy", o_busy, 1'b0);
    chk("stray_grant", o_grant, 0);
    chk("stray_starts", {o_axi_write_start, o_axi_read_start}, 2'b00);
    @(negedge clk);
    chk("stray_done", o_done, 0);
    chk("stray_busy2", o_busy, 1'b0);

    // owner drops request in WAIT, transaction still completes
    req = 3'b010; push(1);
    serve(3, 1'b1);

    // reset during WAIT, then a late done
    req = 3'b010; push(1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!o_axi_read_start && cnt < 30);
    chk("rstw_start", o_axi_read_start, 1'b1);
    e = sb.pop_front();
    chk("rstw_grant", o_grant, N_CH'(1) << e.ch);
    repeat (2) @(negedge clk);
    chk("rstw_busy_pre", o_busy, 1'b1);
    arst = 1'b0; req = '0;
    @(negedge clk);
    chk("rstw_busy", o_busy, 1'b0);
    chk("rstw_grant0", o_grant, 0);
    chk("rstw_addr", o_axi_addr, 0);
    chk("rstw_data", o_data_block, 0);
    chk("rstw_done", o_done, 0);
    arst = 1'b1; axi_done = 1'b1;
    @(negedge clk);
    axi_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_done", o_done, 0);
      chk("late_starts", {o_axi_write_start, o_axi_read_start}, 2'b00);
      chk("late_busy", o_busy, 1'b0);
      @(negedge clk);
    end

    // all three channels at once
    set_ch(0, 1'b1, 64'h0000_0000_0000_1040, {16{32'h1111_0000}});
    set_ch(1, 1'b0, 64'h0000_0000_0000_2085, {16{32'h2222_0000}});
    set_ch(2, 1'b1, 64'h0000_0000_0000_30FF, {16{32'h3333_0000}});
    req = 3'b111;
    push(0); push(1); push(2);
    serve(2, 1'b0);
    serve(1, 1'b0);
    serve(2, 1'b0);

    // ch0 and ch2 request; ch0 re-requests right after its grant completes
    req = 3'b101;
    push(0);
    serve(2, 1'b0);
    req[0] = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push(2); push(0);
`else
    push(0); push(2);
`endif
    serve(1, 1'b0);
    serve(1, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
